// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Recovers pixel coordinates and display-active flag from an
//               incoming active-low hsync/vsync pair, measures line/frame
//               timing and maintains a frame-qualified lock status.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
   parameter int HD          = 640,
   parameter int HF          = 16,
   parameter int HB          = 48,
   parameter int HR          = 96,
   parameter int VD          = 480,
   parameter int VF          = 10,
   parameter int VB          = 33,
   parameter int VR          = 2,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        video_on,
   output logic        locked,
   output logic        sync_err,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines
);

   localparam int HTOT = HD + HF + HB + HR;
   localparam int VTOT = VD + VF + VB + VR;

   localparam logic [9:0]  c_htot_m1 = 10'(HTOT - 1);
   localparam logic [9:0]  c_vtot_m1 = 10'(VTOT - 1);
   localparam logic [9:0]  c_h_load  = 10'(HD + HF);
   localparam logic [9:0]  c_v_load  = 10'(VD + VF);
   localparam logic [9:0]  c_hd      = 10'(HD);
   localparam logic [9:0]  c_vd      = 10'(VD);
   localparam logic [10:0] c_htot    = 11'(HTOT);
   localparam logic [10:0] c_vtot    = 11'(VTOT);
   localparam logic [10:0] c_hr      = 11'(HR);
   localparam logic [10:0] c_loss_m1 = 11'(2 * HTOT - 1);
   localparam logic [10:0] c_sat     = 11'h7FF;
   localparam logic [1:0]  c_lock    = 2'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  good_q, good_d;
   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic [9:0]  pixel_x_q, pixel_x_d;
   logic [9:0]  pixel_y_q, pixel_y_d;
   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] hw_q, hw_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic [10:0] line_len_q, line_len_d;
   logic [10:0] frame_lines_q, frame_lines_d;
   logic        h_seen_q, h_seen_d;
   logic        line_bad_q, line_bad_d;
   logic        sync_err_q, sync_err_d;
   logic        locked_q, locked_d;
   logic        video_on_q, video_on_d;

   logic        w_h_fall, w_h_rise, w_v_fall, w_h_wrap;
   logic [10:0] w_hcnt_inc, w_hw_inc, w_vcnt_inc;
   logic        w_line_viol, w_loss, w_frame_ok;

   // Edges are only recognised on pixel ticks.
   assign w_h_fall   = p_tick & hs_prev_q & ~hsync;
   assign w_h_rise   = p_tick & ~hs_prev_q & hsync;
   assign w_v_fall   = p_tick & vs_prev_q & ~vsync;
   assign w_h_wrap   = ~w_h_fall & (pixel_x_q == c_htot_m1);

   // Saturating increments of the measurement counters.
   assign w_hcnt_inc = (hcnt_q == c_sat) ? hcnt_q : hcnt_q + 11'd1;
   assign w_hw_inc   = (hw_q   == c_sat) ? hw_q   : hw_q   + 11'd1;
   assign w_vcnt_inc = (vcnt_q == c_sat) ? vcnt_q : vcnt_q + 11'd1;

   // A line violation is a wrong period at H fall or a wrong pulse width at
   // H rise, judged only once a reference H fall has been seen.
   assign w_line_viol = h_seen_q & ((w_h_fall & (w_hcnt_inc != c_htot)) |
                                    (w_h_rise & (hw_q != c_hr)));
   // hcnt_q == 2*HTOT-1 means this tick is the 2*HTOT-th without an H fall;
   // equality (not >=) makes the loss report fire once per event.
   assign w_loss      = p_tick & ~w_h_fall & (hcnt_q == c_loss_m1);
   // The current tick's line check belongs to the frame being closed.
   assign w_frame_ok  = (vcnt_q == c_vtot) & ~line_bad_q & ~w_line_viol;

   // Next-state logic: counters, measurements and lock FSM, advanced per tick.
   always_comb begin
      state_d       = state_q;
      good_d        = good_q;
      hs_prev_d     = hs_prev_q;
      vs_prev_d     = vs_prev_q;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      hcnt_d        = hcnt_q;
      hw_d          = hw_q;
      vcnt_d        = vcnt_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      h_seen_d      = h_seen_q;
      line_bad_d    = line_bad_q;
      locked_d      = locked_q;
      video_on_d    = video_on_q;
      sync_err_d    = 1'b0;

      if (p_tick) begin
         hs_prev_d = hsync;
         vs_prev_d = vsync;

         if (w_h_fall)                     pixel_x_d = c_h_load;
         else if (pixel_x_q == c_htot_m1)  pixel_x_d = '0;
         else                              pixel_x_d = pixel_x_q + 10'd1;

         if (w_v_fall)      pixel_y_d = c_v_load;
         else if (w_h_wrap) pixel_y_d = (pixel_y_q == c_vtot_m1) ? '0 : pixel_y_q + 10'd1;

         if (w_h_fall) begin
            line_len_d = w_hcnt_inc;
            hcnt_d     = '0;
            h_seen_d   = 1'b1;
         end else begin
            hcnt_d     = w_hcnt_inc;
         end

         if (!hsync) hw_d = w_h_fall ? 11'd1 : w_hw_inc;
         else        hw_d = '0;

         if (w_v_fall) begin
            frame_lines_d = vcnt_q;
            vcnt_d        = {10'd0, w_h_fall};
         end else if (w_h_fall) begin
            vcnt_d        = w_vcnt_inc;
         end

         if (w_v_fall)         line_bad_d = 1'b0;
         else if (w_line_viol) line_bad_d = 1'b1;

         case (state_q)
            ST_SEARCH: begin
               if (w_v_fall) begin
                  state_d = ST_CHECK;
                  good_d  = 2'd0;
               end
            end
            ST_CHECK: begin
               if (w_v_fall) begin
                  if (w_frame_ok) begin
                     good_d = good_q + 2'd1;
                     if (good_q + 2'd1 == c_lock) state_d = ST_LOCKED;
                  end else begin
                     good_d = 2'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (w_line_viol || (w_v_fall && (vcnt_q != c_vtot))) begin
                  sync_err_d = 1'b1;
                  state_d    = ST_SEARCH;
                  good_d     = 2'd0;
                  h_seen_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               good_d  = 2'd0;
            end
         endcase

         // Signal loss overrides whatever the FSM decided this tick.
         if (w_loss) begin
            sync_err_d = 1'b1;
            state_d    = ST_SEARCH;
            good_d     = 2'd0;
            h_seen_d   = 1'b0;
         end

         locked_d   = (state_d == ST_LOCKED);
         video_on_d = locked_d && (pixel_x_d < c_hd) && (pixel_y_d < c_vd);
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_SEARCH;
         good_q        <= 2'd0;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         hcnt_q        <= '0;
         hw_q          <= '0;
         vcnt_q        <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         h_seen_q      <= 1'b0;
         line_bad_q    <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
         video_on_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         good_q        <= good_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         hcnt_q        <= hcnt_d;
         hw_q          <= hw_d;
         vcnt_q        <= vcnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         h_seen_q      <= h_seen_d;
         line_bad_q    <= line_bad_d;
         sync_err_q    <= sync_err_d;
         locked_q      <= locked_d;
         video_on_q    <= video_on_d;
      end
   end

   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign video_on    = video_on_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;

endmodule
`default_nettype wire
